// File: rtl/dz_modem_monitor_pkg.sv
// Purpose: shared constants and helpers for the DZ11 modem-status monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dz_pkg;

  localparam int DZ_NCHAN       = 8;
  localparam int DZ_SYNC_STAGES = 2;
  localparam int DZ_FILT_LEN    = 16;

  // Debounce counter width: must hold values up to FILT_LEN-1, sized as ceil(log2(FILT_LEN+1)).
  function automatic int dz_cnt_width(input int filt_len);
    return $clog2(filt_len + 1);
  endfunction

endpackage

// File: rtl/dz_modem_monitor_if.sv
// Purpose: groups modem pins, CHG clear/enable controls and MSR/CHG/intr read-back.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are plain levels or one-cycle strobes.
interface dz_modem_monitor_if
  import dz_pkg::*;
#(
  parameter int NCHAN = DZ_NCHAN
) ();

  logic [NCHAN-1:0]   dzCO;
  logic [NCHAN-1:0]   dzRI;
  logic [2*NCHAN-1:0] chgCLR;
  logic               chgIE;
  logic [2*NCHAN-1:0] regMSR;
  logic [2*NCHAN-1:0] regCHG;
  logic               intr;

  // Register/interrupt side: drives pins and controls, reads status.
  modport master (
    output dzCO, dzRI, chgCLR, chgIE,
    input  regMSR, regCHG, intr
  );

  // Monitor side.
  modport slave (
    input  dzCO, dzRI, chgCLR, chgIE,
    output regMSR, regCHG, intr
  );

endinterface

// File: rtl/dz_line_filter.sv
// Purpose: one modem line: SYNC_STAGES-flop synchronizer followed by a FILT_LEN-cycle debounce.
// Latency: input stable from edge k reaches f at edge k+SYNC_STAGES+FILT_LEN-1.
// Backpressure: none; free-running per clock.
module dz_line_filter
  import dz_pkg::*;
#(
  parameter int SYNC_STAGES = DZ_SYNC_STAGES,
  parameter int FILT_LEN    = DZ_FILT_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic f,
  output logic tgl
);

  localparam int            CW       = dz_cnt_width(FILT_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q;
  logic                   f_q;

  // Plain flop chain; nothing between stages so metastability has the full period to settle.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Asserted on the cycle whose edge flips f; lets the top set CHG on the same edge as MSR moves.
  assign tgl = (s != f_q) && (cnt_q == CNT_LAST);

  // Debounce: count consecutive cycles of disagreement, adopt s once the count completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else if (s == f_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      f_q   <= s;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign f = f_q;

endmodule

// File: rtl/dz_modem_monitor.sv
// Purpose: N-channel CO/RI modem-status front end: filtered MSR, sticky CHG flags, change interrupt.
// Latency: edge at k -> regMSR/regCHG at k+SYNC_STAGES+FILT_LEN-1, intr one edge later.
// Backpressure: none; chgCLR is a write-1-to-clear strobe and loses to a same-cycle set.
module dz_modem_monitor
  import dz_pkg::*;
#(
  parameter int NCHAN       = DZ_NCHAN,
  parameter int SYNC_STAGES = DZ_SYNC_STAGES,
  parameter int FILT_LEN    = DZ_FILT_LEN
) (
  input logic               clk,
  input logic               rst,
  dz_modem_monitor_if.slave bus
);

  localparam int NL = 2 * NCHAN;

  if (NCHAN < 1) begin : g_bad_nchan
    $error("dz_modem_monitor: NCHAN must be at least 1");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("dz_modem_monitor: SYNC_STAGES must be 2..4");
  end
  if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_bad_filt
    $error("dz_modem_monitor: FILT_LEN must be 1..255");
  end

  logic [NL-1:0] line_in;
  logic [NL-1:0] f_vec;
  logic [NL-1:0] tgl_vec;
  logic [NL-1:0] chg_q;
  logic          intr_q;

  // RI occupies the low half, CO the high half, matching the MSR read layout.
  assign line_in = {bus.dzCO, bus.dzRI};

  for (genvar i = 0; i < NL; i++) begin : g_line
    dz_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
    ) u_filt (
      .clk (clk),
      .rst (rst),
      .din (line_in[i]),
      .f   (f_vec[i]),
      .tgl (tgl_vec[i])
    );
  end

  // Sticky change flags: a toggle sets, chgCLR clears, a set in the same cycle wins.
  always_ff @(posedge clk) begin
    if (rst) chg_q <= '0;
    else     chg_q <= (chg_q & ~bus.chgCLR) | tgl_vec;
  end

  // Level interrupt from the registered flags, so it trails any flag change by one edge.
  always_ff @(posedge clk) begin
    if (rst) intr_q <= 1'b0;
    else     intr_q <= bus.chgIE & (|chg_q);
  end

  assign bus.regMSR = f_vec;
  assign bus.regCHG = chg_q;
  assign bus.intr   = intr_q;

endmodule

// File: tb/tb_dz_modem_monitor.sv
// Purpose: self-checking bench for dz_modem_monitor in two configurations (8ch/FILT 4, 4ch/FILT 1).
// Latency: expectations are scheduled per cycle from the documented pipeline latency.
// Backpressure: n/a.
module tb_dz_modem_monitor;
  import dz_pkg::*;

  typedef struct {
    int          cyc;
    logic [32:0] v;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   nvec;
  int   nerr;
  exp_t sbq[$];

  dz_modem_monitor_if #(.NCHAN(8)) a_if ();
  dz_modem_monitor_if #(.NCHAN(4)) b_if ();

  dz_modem_monitor #(.NCHAN(8), .SYNC_STAGES(2), .FILT_LEN(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  dz_modem_monitor #(.NCHAN(4), .SYNC_STAGES(2), .FILT_LEN(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  logic [32:0] obs_a;
  logic [16:0] obs_b;
  assign obs_a = {a_if.regMSR, a_if.regCHG, a_if.intr};
  assign obs_b = {b_if.regMSR, b_if.regCHG, b_if.intr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] pk_a(input logic [15:0] m, input logic [15:0] c, input logic i);
    return {m, c, i};
  endfunction

  function automatic logic [32:0] pk_b(input logic [7:0] m, input logic [7:0] c, input logic i);
    return {16'h0000, m, c, i};
  endfunction

  // Advance one edge, then sit 1ns past it so outputs are settled and inputs can be changed safely.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    for (int r = 1; r <= 53; r++) begin
      e.cyc = cyc + r;
      e.v   = pk_a(16'h0000, 16'h0000, 1'b0);
      sbq.push_back(e);
    end
    for (int r = 1; r <= 53; r++) begin
      step();
      e = sbq.pop_front();
      nvec++;
      if (obs_a !== e.v) begin
        nerr++;
        $display("FAIL reset_a cyc=%0d got=%h want=%h", e.cyc, obs_a, e.v);
      end
      nvec++;
      if (obs_b !== 17'h0) begin
        nerr++;
        $display("FAIL reset_b cyc=%0d got=%h want=0", e.cyc, obs_b);
      end
      if (r == 3) rst = 1'b0;
    end
  endtask

  task automatic test_clean_edge();
    exp_t e;
    a_if.chgIE   = 1'b1;
    a_if.dzCO[3] = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      e.cyc = cyc + r;
      e.v   = pk_a((r >= 6) ? 16'h0800 : 16'h0000,
                   (r >= 6 && r <= 8) ? 16'h0800 : 16'h0000,
                   r >= 7 && r <= 9);
      sbq.push_back(e);
    end
    for (int r = 1; r <= 10; r++) begin
      step();
      e = sbq.pop_front();
      nvec++;
      if (obs_a !== e.v) begin
        nerr++;
        $display("FAIL clean_edge cyc=%0d got=%h want=%h", e.cyc, obs_a, e.v);
      end
      if (r == 8) a_if.chgCLR = 16'h0800;
      if (r == 9) a_if.chgCLR = '0;
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    a_if.dzRI[0] = 1'b1;
    for (int r = 1; r <= 26; r++) begin
      e.cyc = cyc + r;
      e.v   = pk_a(16'h0800 | ((r >= 18 && r <= 21) ? 16'h0001 : 16'h0000),
                   (r >= 18) ? 16'h0001 : 16'h0000,
                   r >= 19);
      sbq.push_back(e);
    end
    for (int r = 1; r <= 26; r++) begin
      step();
      e = sbq.pop_front();
      nvec++;
      if (obs_a !== e.v) begin
        nerr++;
        $display("FAIL glitch cyc=%0d got=%h want=%h", e.cyc, obs_a, e.v);
      end
      if (r == 3)  a_if.dzRI[0] = 1'b0;
      if (r == 12) a_if.dzRI[0] = 1'b1;
      if (r == 16) a_if.dzRI[0] = 1'b0;
    end
  endtask

  task automatic test_clear_priority();
    exp_t e;
    a_if.dzRI[0] = 1'b1;
    for (int r = 1; r <= 11; r++) begin
      e.cyc = cyc + r;
      e.v   = pk_a(16'h0800 | ((r >= 6) ? 16'h0001 : 16'h0000),
                   (r <= 8) ? 16'h0001 : 16'h0000,
                   r <= 9);
      sbq.push_back(e);
    end
    for (int r = 1; r <= 11; r++) begin
      step();
      e = sbq.pop_front();
      nvec++;
      if (obs_a !== e.v) begin
        nerr++;
        $display("FAIL clear_priority cyc=%0d got=%h want=%h", e.cyc, obs_a, e.v);
      end
      if (r == 5) a_if.chgCLR = 16'h0001;
      if (r == 6) a_if.chgCLR = '0;
      if (r == 8) a_if.chgCLR = 16'h0001;
      if (r == 9) a_if.chgCLR = '0;
    end
  endtask

  task automatic test_intr_enable();
    exp_t e;
    a_if.chgIE   = 1'b0;
    a_if.dzRI[0] = 1'b0;
    a_if.dzCO[7] = 1'b1;
    for (int r = 1; r <= 14; r++) begin
      e.cyc = cyc + r;
      e.v   = pk_a((r >= 6) ? 16'h8800 : 16'h0801,
                   (r >= 6 && r <= 12) ? 16'h8001 : 16'h0000,
                   r >= 10 && r <= 11);
      sbq.push_back(e);
    end
    for (int r = 1; r <= 14; r++) begin
      step();
      e = sbq.pop_front();
      nvec++;
      if (obs_a !== e.v) begin
        nerr++;
        $display("FAIL intr_enable cyc=%0d got=%h want=%h", e.cyc, obs_a, e.v);
      end
      if (r == 9)  a_if.chgIE  = 1'b1;
      if (r == 11) a_if.chgIE  = 1'b0;
      if (r == 12) a_if.chgCLR = 16'hFFFF;
      if (r == 13) a_if.chgCLR = '0;
    end
  endtask

  task automatic test_reset_mid_count();
    exp_t e;
    a_if.chgIE   = 1'b1;
    a_if.dzRI[1] = 1'b1;
    for (int r = 1; r <= 13; r++) begin
      e.cyc = cyc + r;
      e.v   = pk_a((r <= 4) ? 16'h8800 : ((r >= 11) ? 16'h8802 : 16'h0000),
                   (r >= 11) ? 16'h8802 : 16'h0000,
                   r >= 12);
      sbq.push_back(e);
    end
    for (int r = 1; r <= 13; r++) begin
      step();
      e = sbq.pop_front();
      nvec++;
      if (obs_a !== e.v) begin
        nerr++;
        $display("FAIL reset_mid_count cyc=%0d got=%h want=%h", e.cyc, obs_a, e.v);
      end
      if (r == 4) rst = 1'b1;
      if (r == 5) rst = 1'b0;
    end
  endtask

  task automatic test_narrow_fast();
    exp_t e;
    b_if.chgIE   = 1'b1;
    b_if.dzCO[1] = 1'b1;
    for (int r = 1; r <= 11; r++) begin
      e.cyc = cyc + r;
      e.v   = pk_b((r >= 3 && r <= 5) ? 8'h20 : ((r >= 9) ? 8'h24 : 8'h00),
                   (r >= 3 && r <= 5) ? 8'h20 : ((r >= 9) ? 8'h24 : 8'h00),
                   (r >= 4 && r <= 5) || r >= 10);
      sbq.push_back(e);
    end
    for (int r = 1; r <= 11; r++) begin
      step();
      e = sbq.pop_front();
      nvec++;
      if ({16'h0000, obs_b} !== e.v) begin
        nerr++;
        $display("FAIL narrow_fast cyc=%0d got=%h want=%h", e.cyc, obs_b, e.v[16:0]);
      end
      if (r == 4) b_if.dzRI[2] = 1'b1;
      if (r == 5) rst = 1'b1;
      if (r == 6) rst = 1'b0;
    end
  endtask

  initial begin
    cyc  = 0;
    nvec = 0;
    nerr = 0;
    rst  = 1'b1;
    a_if.dzCO   = '0;
    a_if.dzRI   = '0;
    a_if.chgCLR = '0;
    a_if.chgIE  = 1'b0;
    b_if.dzCO   = '0;
    b_if.dzRI   = '0;
    b_if.chgCLR = '0;
    b_if.chgIE  = 1'b0;

    test_reset();
    test_clean_edge();
    test_glitch();
    test_clear_priority();
    test_intr_enable();
    test_reset_mid_count();
    test_narrow_fast();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dz_modem_monitor.md
# dz_modem_monitor

Parametrised modem-status front end for the DZ11 family. It takes the asynchronous carrier-detect (CO) and ring-indicator (RI) lines for N channels and runs each one through a multi-stage synchronizer and a per-line debounce filter. It presents the filtered levels as the MSR read value and latches per-line change flags that can raise a modem-change interrupt. It sits between the board-level modem pins and the DZ11 register/interrupt logic, and replaces the fixed 8-channel two-flop MSR synchronizer.

## Interface
- NCHAN, 8: number of channels; MSR width is 2*NCHAN.
- SYNC_STAGES, 2: synchronizer flops per line; legal values are 2 to 4.
- FILT_LEN, 16: consecutive differing cycles needed before the filtered level changes; legal values are 1 to 255.

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- dzCO  in  NCHAN  carrier detect, asynchronous
- dzRI  in  NCHAN  ring indicator, asynchronous
- chgCLR  in  2*NCHAN  write-1-to-clear strobe for regCHG, one cycle wide; bit layout matches regMSR
- chgIE  in  1  modem-change interrupt enable
- regMSR  out  2*NCHAN  filtered levels: {CO[NCHAN-1:0], RI[NCHAN-1:0]}
- regCHG  out  2*NCHAN  latched change flags, same layout as regMSR
- intr  out  1  modem-change interrupt request, level, registered

## Operation
Each of the 2*NCHAN lines is processed independently. Line i of regMSR/regCHG maps to RI[i] for i < NCHAN and to CO[i-NCHAN] otherwise.
- **Synchronizer:** a SYNC_STAGES-deep flop chain. The synced value s is the last stage. No logic sits between stages.
- **Debounce:** each line has a filtered level f and a counter cnt of ceil(log2(FILT_LEN+1)) bits.
  - If s == f: cnt <= 0.
  - If s != f and cnt == FILT_LEN-1: f <= s and cnt <= 0.
  - If s != f otherwise: cnt <= cnt+1.
  - A glitch shorter than FILT_LEN cycles never reaches f.
  - With FILT_LEN=1, f follows s one cycle later.
- **Change latch:** on the edge where f toggles, regCHG[i] <= 1. On chgCLR[i], regCHG[i] <= 0.
  - If a set and a clear land in the same cycle, set wins and the bit reads 1.
  - A bit stays 1 across any number of further toggles.
- **Interrupt:** intr <= chgIE & |regCHG.
  - Deasserts one cycle after the last flag clears or after chgIE drops.
  - There is no edge semantics; the consumer samples the level.

## Timing
- **Reset:** rst clears all sync flops, f, cnt and regCHG, and intr. regMSR, regCHG and intr all read 0 on the first edge after rst.
  - The filter therefore treats a line already high as a change: f rises and the CHG bit sets SYNC_STAGES+FILT_LEN cycles after rst drops. This is intended.
- **Reset mid-operation:** a debounce in progress is discarded. It restarts from cnt=0, f=0.
- **Latency:** an input edge stable from clock edge k appears on regMSR at edge k+SYNC_STAGES+FILT_LEN-1.
  - regCHG sets on that same edge.
  - intr asserts one edge later.
- **Counter limits:** cnt never exceeds FILT_LEN-1 and never wraps.
- **Toggle during count:** an input that returns to f mid-count resets cnt the cycle after s matches f.
- **Read path:** there is no combinational path from any input to any output.

## Structure
- Package dz_pkg holds:
  - the default constants (DZ_NCHAN=8, DZ_SYNC_STAGES=2, DZ_FILT_LEN=16);
  - a function returning the counter width for a given FILT_LEN.
- One sub-module, dz_line_filter: a single-bit synchronizer plus debounce. Parameters SYNC_STAGES and FILT_LEN; output f and a one-cycle toggle pulse.
- The top generates 2*NCHAN filter instances plus the regCHG/intr logic. Parameter legality is checked with elaboration-time assertions.

## Test plan
- **Reset with lines low:** NCHAN=8, FILT_LEN=4, all lines low, assert rst for 3 cycles -> regMSR=0, regCHG=0 and intr=0, and they remain 0 for 50 cycles.
- **Clean edge:** raise dzCO[3] and hold -> regMSR[11] rises exactly 5 edges (SYNC_STAGES+FILT_LEN-1) after the first sampling edge. regCHG = 16'h0800 on the same edge; with chgIE=1, intr rises one edge later.
- **Glitch rejection:** pulse dzRI[0] high for 3 cycles (< FILT_LEN=4) -> regMSR and regCHG stay 0. A 4-cycle pulse -> regMSR[0] goes high for exactly 4 cycles, and regCHG[0] = 1 and stays 1.
- **Clear priority:** with regCHG[0]=1 and a second toggle completing in the same cycle as chgCLR[0] -> regCHG[0] stays 1. A chgCLR[0] on an idle cycle -> regCHG[0] = 0 next edge, and intr drops one edge after that.
- **Interrupt enable:** set regCHG bits with chgIE=0 -> intr stays 0. Raise chgIE -> intr = 1 one edge later.
- **Reset mid-count:** assert rst while cnt=2 on a line that is still high -> after release, the line rises at the full SYNC_STAGES+FILT_LEN latency, not the remaining count. Repeat with NCHAN=4 and FILT_LEN=1 -> regMSR is 8 bits wide and latency is SYNC_STAGES edges.
